// File: rtl/param_stack.sv
// param_stack: LIFO of DEPTH words, WIDTH bits each.
// The popped word and the top word are both combinational and come from the stored array only.
// A newly pushed value therefore appears on top one cycle later.
// Push and pop in the same cycle replaces the top word, so it still works when the stack is full.
// A rejected request raises overflow/underflow for the following cycle and also sets err_sticky.
// Only rst clears err_sticky.
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           value,
    output logic [WIDTH-1:0]           out,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       err_sticky
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             err_q, err_d;

    logic             acc_push, acc_pop;
    logic [AW-1:0]    top_idx, wr_idx;
    logic [WIDTH-1:0] top_word;

    // Request decode, read path and next-state computation
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        acc_pop  = pop & ~empty;
        acc_push = push & (~full | acc_pop);

        // Only index count-1 is ever read, so stale entries stay hidden
        top_idx  = empty ? '0 : AW'(count_q - CW'(1));
        top_word = empty ? '0 : mem_q[top_idx];

        // Replace-top reuses the top slot; a plain push fills slot count
        wr_idx   = acc_pop ? top_idx : AW'(count_q);

        count_d = count_q;
        if (acc_push && !acc_pop) begin
            count_d = count_q + CW'(1);
        end else if (acc_pop && !acc_push) begin
            count_d = count_q - CW'(1);
        end

        overflow_d  = push & ~acc_push;
        underflow_d = pop & ~acc_pop;
        err_d       = err_q | overflow_d | underflow_d;

        out        = acc_pop ? top_word : '0;
        top        = top_word;
        count      = count_q;
        overflow   = overflow_q;
        underflow  = underflow_q;
        err_sticky = err_q;
    end

    // Control and status registers; rst wins over any request in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            err_q       <= err_d;
        end
    end

    // Storage array, left unreset; writes are dropped during rst
    always_ff @(posedge clk) begin
        if (!rst && acc_push) begin
            mem_q[wr_idx] <= value;
        end
    end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 256, number of stack entries (>=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port push  input  1  push request for this cycle.
REQ-006 SHALL have port pop  input  1  pop request for this cycle.
REQ-007 SHALL have port value  input  WIDTH  data to push.
REQ-008 SHALL have port out  output  WIDTH  popped word, combinational, valid in the cycle of an accepted pop, else 0.
REQ-009 SHALL have port top  output  WIDTH  current top-of-stack word, combinational; 0 when empty.
REQ-010 SHALL have port count  output  $clog2(DEPTH+1)  number of stored entries.
REQ-011 SHALL have ports full and empty  output  1 each  count==DEPTH / count==0.
REQ-012 SHALL have ports overflow and underflow  output  1 each  registered one-cycle error pulses.
REQ-013 SHALL have port err_sticky  output  1  set by any overflow/underflow, cleared only by rst.

Function
REQ-014 SHALL store entries in a DEPTH x WIDTH array indexed 0..DEPTH-1; entry count-1 is top.
REQ-015 SHALL decode per cycle: acc_pop = pop & !empty; acc_push = push & (!full | acc_pop).
REQ-016 Push only (acc_push, !acc_pop): SHALL write value to entry count and increment count at the edge.
REQ-017 Pop only (acc_pop, !acc_push): SHALL drive out = top in that cycle and decrement count at the edge.
REQ-018 Push+pop both accepted: SHALL drive out = old top, overwrite entry count-1 with value, leave count unchanged (replace-top), including when full.
REQ-019 Push+pop while empty: SHALL reject pop (underflow pulse), accept push as push-only.
REQ-020 Push only while full: SHALL reject push, leave array and count unchanged, pulse overflow next cycle.
REQ-021 Pop while empty: SHALL leave state unchanged, out = 0, pulse underflow next cycle.
REQ-022 overflow/underflow SHALL be high for exactly the one cycle following the rejected request; consecutive rejects give continuous high.
REQ-023 top SHALL reflect a push/replace in the cycle after the edge (no same-cycle bypass of value to top or out).
REQ-024 count SHALL never exceed DEPTH nor wrap below 0; no pointer wrap-around is permitted.
REQ-025 Latency: push-to-top 1 cycle; pop-to-out 0 cycles (combinational); flags 1 cycle after the edge.
REQ-026 Neither out nor top SHALL ever expose an entry at index >= count.

Reset
REQ-027 On rst high at a rising edge: count=0, empty=1, full=0, overflow=0, underflow=0, err_sticky=0; top=0, out=0.
REQ-028 rst SHALL take priority over simultaneous push/pop; requests in the reset cycle are discarded with no error pulse.
REQ-029 Array contents SHALL not require reset; stale data SHALL be unobservable per REQ-026.
REQ-030 Reset mid-operation (any count) SHALL yield the REQ-027 state on the next cycle.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Push 0x11,0x22,0x33,0x44 -> count 1..4, top=0x44, full=1 after 4th edge; pop x4 -> out 0x44,0x33,0x22,0x11, empty=1.
REQ-032 Full, push 0x55 only -> overflow=1 for one cycle, err_sticky=1, top stays 0x44, count=4.
REQ-033 Full, push 0x66 + pop same cycle -> out=0x44 that cycle, next cycle top=0x66, count=4, no overflow.
REQ-034 Empty, pop -> out=0, underflow=1 next cycle; empty, push 0x77 + pop -> count=1, top=0x77, underflow=1.
REQ-035 count=3, assert rst with push 0x99 -> next cycle count=0, empty=1, top=0, all error flags 0.
REQ-036 Random push/pop 10k cycles vs reference model -> out, top, count, flags match every cycle.
